// File: rtl/cmp_branch_ctrl.sv
// Branch-resolution controller: drives a 4-bit comparator, samples its flags
// after a programmable settle time, resolves the branch and updates the PC.
module cmp_branch_ctrl #(
  parameter int PC_W          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      br_op,
  input  logic [3:0]      op_a,
  input  logic [3:0]      op_b,
  input  logic [PC_W-1:0] br_target,
  output logic [3:0]      cmp_A,
  output logic [3:0]      cmp_B,
  output logic            cmp_isEqual,
  output logic            cmp_isGreater,
  output logic            cmp_isLess,
  input  logic            cmp_equal,
  input  logic            cmp_A_greater,
  input  logic            cmp_A_less,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            taken,
  output logic [2:0]      last_flags,
  output logic            cmp_err
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [1:0]      OP_BEQ      = 2'b00;
  localparam logic [1:0]      OP_BGT      = 2'b01;
  localparam logic [1:0]      OP_BLT      = 2'b10;
  localparam logic [1:0]      OP_JMP      = 2'b11;
  localparam logic [2:0]      SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_ONE      = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [2:0]      settle_cnt;
  logic [1:0]      br_op_p0;
  logic [PC_W-1:0] br_target_p0;
  logic [2:0]      flags;
  logic            flags_ok;
  logic            br_hit;
  logic            accept;

  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

  function automatic logic cond_met(input logic [1:0] op, input logic [2:0] f);
    case (op)
      OP_BEQ:  return f[2];
      OP_BGT:  return f[1];
      OP_BLT:  return f[0];
      default: return 1'b0;
    endcase
  endfunction

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;
  assign flags       = {cmp_equal, cmp_A_greater, cmp_A_less};
  assign flags_ok    = is_onehot3(flags);
  assign br_hit      = flags_ok & cond_met(br_op_p0, flags);

  // Accept stage: instruction fields captured for use at resolve time
  always_ff @(posedge clk) begin
    if (accept) begin
      br_op_p0     <= br_op;
      br_target_p0 <= br_target;
    end
  end

  // Control and resolve stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= 3'd0;
      pc            <= '0;
      done          <= 1'b0;
      taken         <= 1'b0;
      last_flags    <= 3'b000;
      cmp_err       <= 1'b0;
      cmp_A         <= 4'd0;
      cmp_B         <= 4'd0;
      cmp_isEqual   <= 1'b0;
      cmp_isGreater <= 1'b0;
      cmp_isLess    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (br_op == OP_JMP) begin
              pc    <= br_target;
              taken <= 1'b1;
              done  <= 1'b1;
            end else begin
              cmp_A         <= op_a;
              cmp_B         <= op_b;
              cmp_isEqual   <= (br_op == OP_BEQ);
              cmp_isGreater <= (br_op == OP_BGT);
              cmp_isLess    <= (br_op == OP_BLT);
              settle_cnt    <= SETTLE_LOAD;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (settle_cnt != 3'd0) begin
            settle_cnt <= settle_cnt - 3'd1;
          end else begin
            last_flags    <= flags;
            taken         <= br_hit;
            pc            <= br_hit ? br_target_p0 : pc + PC_ONE;
            done          <= 1'b1;
            cmp_isEqual   <= 1'b0;
            cmp_isGreater <= 1'b0;
            cmp_isLess    <= 1'b0;
            state         <= IDLE;
            // A non-one-hot flag pattern means a broken comparator; remember it
            if (!flags_ok) cmp_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_branch_ctrl.sv
// Directed self-checking bench for cmp_branch_ctrl (settle 1 and settle 3 instances).
module tb_cmp_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_valid3;
  logic [1:0] br_op;
  logic [3:0] op_a, op_b, br_target;
  logic       cmp_equal, cmp_A_greater, cmp_A_less;

  logic       instr_ready, cmp_isEqual, cmp_isGreater, cmp_isLess, done, taken, cmp_err;
  logic [3:0] cmp_A, cmp_B, pc;
  logic [2:0] last_flags;

  logic       instr_ready3, cmp_isEqual3, cmp_isGreater3, cmp_isLess3, done3, taken3, cmp_err3;
  logic [3:0] cmp_A3, cmp_B3, pc3;
  logic [2:0] last_flags3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmp_branch_ctrl #(.PC_W(4), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_op(br_op), .op_a(op_a), .op_b(op_b), .br_target(br_target),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_isEqual(cmp_isEqual),
    .cmp_isGreater(cmp_isGreater), .cmp_isLess(cmp_isLess),
    .cmp_equal(cmp_equal), .cmp_A_greater(cmp_A_greater), .cmp_A_less(cmp_A_less),
    .pc(pc), .done(done), .taken(taken), .last_flags(last_flags), .cmp_err(cmp_err)
  );

  cmp_branch_ctrl #(.PC_W(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
    .br_op(br_op), .op_a(op_a), .op_b(op_b), .br_target(br_target),
    .cmp_A(cmp_A3), .cmp_B(cmp_B3), .cmp_isEqual(cmp_isEqual3),
    .cmp_isGreater(cmp_isGreater3), .cmp_isLess(cmp_isLess3),
    .cmp_equal(cmp_equal), .cmp_A_greater(cmp_A_greater), .cmp_A_less(cmp_A_less),
    .pc(pc3), .done(done3), .taken(taken3), .last_flags(last_flags3), .cmp_err(cmp_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {cmp_equal, cmp_A_greater, cmp_A_less} = f;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] tgt);
    br_op = op; op_a = a; op_b = b; br_target = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr_valid3 = 1'b0;
    issue(2'b00, 4'd0, 4'd0, 4'd0); set_flags(3'b000);
    tick(); tick();
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", pc); end
    n_checks++; if ({done, taken, cmp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl: got %b want 000", {done, taken, cmp_err}); end
    n_checks++; if (last_flags !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", last_flags); end
    n_checks++; if ({cmp_A, cmp_B, cmp_isEqual, cmp_isGreater, cmp_isLess} !== 11'd0) begin n_fail++; $display("FAIL rst_cmp: got %h want 0", {cmp_A, cmp_B, cmp_isEqual, cmp_isGreater, cmp_isLess}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_taken();
    issue(2'b00, 4'd5, 4'd5, 4'd9); set_flags(3'b100); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL beq_early_done: got %b want 0", done); end
    n_checks++; if ({cmp_isEqual, cmp_isGreater, cmp_isLess} !== 3'b100) begin n_fail++; $display("FAIL beq_mode: got %b want 100", {cmp_isEqual, cmp_isGreater, cmp_isLess}); end
    n_checks++; if ({cmp_A, cmp_B} !== 8'h55) begin n_fail++; $display("FAIL beq_operands: got %h want 55", {cmp_A, cmp_B}); end
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL beq_busy: got %b want 0", instr_ready); end
    tick();
    n_checks++; if ({done, taken} !== 2'b11) begin n_fail++; $display("FAIL beq_done_taken: got %b want 11", {done, taken}); end
    n_checks++; if (pc !== 4'd9) begin n_fail++; $display("FAIL beq_pc: got %0d want 9", pc); end
    n_checks++; if ({cmp_isEqual, cmp_isGreater, cmp_isLess} !== 3'b000) begin n_fail++; $display("FAIL beq_mode_clr: got %b want 000", {cmp_isEqual, cmp_isGreater, cmp_isLess}); end
    n_checks++; if (last_flags !== 3'b100) begin n_fail++; $display("FAIL beq_flags: got %b want 100", last_flags); end
    tick();
    n_checks++; if ({done, taken} !== 2'b01) begin n_fail++; $display("FAIL beq_pulse: got %b want 01", {done, taken}); end
  endtask

  task automatic test_bgt_not_taken();
    issue(2'b01, 4'd3, 4'd12, 4'd2); set_flags(3'b001); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if ({cmp_isEqual, cmp_isGreater, cmp_isLess} !== 3'b010) begin n_fail++; $display("FAIL bgt_mode: got %b want 010", {cmp_isEqual, cmp_isGreater, cmp_isLess}); end
    n_checks++; if ({cmp_A, cmp_B} !== 8'h3c) begin n_fail++; $display("FAIL bgt_operands: got %h want 3c", {cmp_A, cmp_B}); end
    tick();
    n_checks++; if ({done, taken} !== 2'b10) begin n_fail++; $display("FAIL bgt_done_taken: got %b want 10", {done, taken}); end
    n_checks++; if (pc !== 4'd10) begin n_fail++; $display("FAIL bgt_pc: got %0d want 10", pc); end
    n_checks++; if (last_flags !== 3'b001) begin n_fail++; $display("FAIL bgt_flags: got %b want 001", last_flags); end
  endtask

  task automatic test_back_to_back();
    issue(2'b11, 4'd0, 4'd0, 4'd15); instr_valid = 1'b1;
    tick();
    n_checks++; if ({done, taken, instr_ready} !== 3'b111) begin n_fail++; $display("FAIL jmp15_ctl: got %b want 111", {done, taken, instr_ready}); end
    n_checks++; if (pc !== 4'd15) begin n_fail++; $display("FAIL jmp15_pc: got %0d want 15", pc); end
    // New BLT accepted in the same cycle the JMP done is high
    issue(2'b10, 4'd9, 4'd2, 4'd3); set_flags(3'b010);
    tick();
    instr_valid = 1'b0;
    n_checks++; if ({done, cmp_isLess} !== 2'b01) begin n_fail++; $display("FAIL b2b_accept: got %b want 01", {done, cmp_isLess}); end
    n_checks++; if (last_flags !== 3'b001) begin n_fail++; $display("FAIL jmp_keeps_flags: got %b want 001", last_flags); end
    tick();
    n_checks++; if ({done, taken} !== 2'b10) begin n_fail++; $display("FAIL wrap_done_taken: got %b want 10", {done, taken}); end
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d want 0", pc); end
    issue(2'b11, 4'd1, 4'd1, 4'd7); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if ({done, taken, pc} !== {2'b11, 4'd7}) begin n_fail++; $display("FAIL jmp7: got %b want 117", {done, taken, pc}); end
    n_checks++; if ({cmp_isEqual, cmp_isGreater, cmp_isLess} !== 3'b000) begin n_fail++; $display("FAIL jmp_mode: got %b want 000", {cmp_isEqual, cmp_isGreater, cmp_isLess}); end
    n_checks++; if ({cmp_A, cmp_B, last_flags} !== {4'd9, 4'd2, 3'b010}) begin n_fail++; $display("FAIL jmp_hold: got %h want 922", {cmp_A, cmp_B, last_flags}); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL jmp_pulse: got %b want 0", done); end
  endtask

  task automatic test_settle3();
    issue(2'b10, 4'd2, 4'd8, 4'd11); set_flags(3'b000); instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    n_checks++; if ({done3, cmp_isLess3, instr_ready3} !== 3'b010) begin n_fail++; $display("FAIL s3_accept: got %b want 010", {done3, cmp_isLess3, instr_ready3}); end
    set_flags(3'b100);
    issue(2'b11, 4'd0, 4'd0, 4'd5); instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    n_checks++; if ({done3, instr_ready3, pc3} !== {2'b00, 4'd0}) begin n_fail++; $display("FAIL s3_ignore_valid: got %h want 0", {done3, instr_ready3, pc3}); end
    set_flags(3'b010);
    tick();
    n_checks++; if ({done3, cmp_isLess3} !== 2'b01) begin n_fail++; $display("FAIL s3_wait: got %b want 01", {done3, cmp_isLess3}); end
    set_flags(3'b001);
    tick();
    n_checks++; if ({done3, taken3, pc3} !== {2'b11, 4'd11}) begin n_fail++; $display("FAIL s3_resolve: got %h want 3b", {done3, taken3, pc3}); end
    n_checks++; if ({last_flags3, cmp_err3} !== 4'b0010) begin n_fail++; $display("FAIL s3_flags: got %b want 0010", {last_flags3, cmp_err3}); end
  endtask

  task automatic test_flag_err();
    issue(2'b01, 4'd7, 4'd1, 4'd4); set_flags(3'b011); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    n_checks++; if ({done, taken, pc} !== {2'b10, 4'd8}) begin n_fail++; $display("FAIL err_resolve: got %h want 28", {done, taken, pc}); end
    n_checks++; if ({cmp_err, last_flags} !== 4'b1011) begin n_fail++; $display("FAIL err_flag: got %b want 1011", {cmp_err, last_flags}); end
    issue(2'b00, 4'd2, 4'd2, 4'd1); set_flags(3'b100); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    n_checks++; if ({done, taken, pc} !== {2'b11, 4'd1}) begin n_fail++; $display("FAIL err_next_ok: got %h want 31", {done, taken, pc}); end
    n_checks++; if (cmp_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", cmp_err); end
  endtask

  task automatic test_reset_mid_issue();
    issue(2'b01, 4'd9, 4'd4, 4'd13); set_flags(3'b010); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if ({cmp_isGreater, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_issue: got %b want 10", {cmp_isGreater, instr_ready}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({done, taken, cmp_err, pc} !== 7'd0) begin n_fail++; $display("FAIL mid_rst_ctl: got %h want 0", {done, taken, cmp_err, pc}); end
    n_checks++; if ({cmp_A, cmp_B, cmp_isGreater, last_flags} !== 12'd0) begin n_fail++; $display("FAIL mid_rst_cmp: got %h want 0", {cmp_A, cmp_B, cmp_isGreater, last_flags}); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", instr_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if ({done, instr_ready, pc} !== {2'b01, 4'd0}) begin n_fail++; $display("FAIL post_rst: got %h want 10", {done, instr_ready, pc}); end
    tick();
    n_checks++; if ({done, cmp_err} !== 2'b00) begin n_fail++; $display("FAIL post_rst_quiet: got %b want 00", {done, cmp_err}); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bgt_not_taken();
    test_back_to_back();
    test_settle3();
    test_flag_err();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
